// File: rtl/mdu_stall_ctrl_pkg.sv
// Shared encodings for the MIPS hazard/stall controller: Tuse/Tnew codes,
// MDU busy-FSM state codes and the register-hazard compare helper.
package mdu_stall_ctrl_pkg;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   // $0 never hazards; an unused operand (TUSE_NONE) can never be younger than any Tnew.
   function automatic logic reg_hazard(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] a3,
                                       input logic [1:0] tnew);
      return (src != 5'd0) && (src == a3) && (tuse != TUSE_NONE) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/mdu_stall_ctrl_mdu_busy_fsm.sv
// Multi-cycle mult/div occupancy tracker: IDLE/BUSY state, down-counter and
// the registered one-cycle HI/LO commit strobe.
module mdu_busy_fsm
   import mdu_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       is_div,
   output mdu_state_e state,
   output logic       hilo_we
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] load;
   logic             hilo_q, hilo_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         hilo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hilo_q  <= hilo_d;
      end
   end

   // The strobe is registered: it is raised in the cycle the counter lands on
   // zero, which is the first IDLE cycle after the operation, i.e. start + N.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hilo_d  = 1'b0;
      load    = is_div ? DIV_LOAD : MULT_LOAD;
      case (state_q)
         MDU_IDLE: begin
            if (start) begin
               if (load == '0) begin
                  hilo_d = 1'b1;
               end else begin
                  state_d = MDU_BUSY;
                  cnt_d   = load;
               end
            end
         end
         MDU_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_d = MDU_IDLE;
               cnt_d   = '0;
               hilo_d  = 1'b1;
            end
         end
         default: begin
            state_d = MDU_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      state   = state_q;
      hilo_we = hilo_q;
   end

endmodule

// File: rtl/mdu_stall_ctrl.sv
// Pipeline stall controller: Tuse/Tnew data hazards plus mult/div occupancy.
// Optional stall-cycle performance counter enabled by STALL_PERF_CNT_EN.
module mdu_stall_ctrl
   import mdu_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  tuse_rs_D,
   input  logic [1:0]  tuse_rt_D,
   input  logic [4:0]  A3_E,
   input  logic [1:0]  tnew_E,
   input  logic [4:0]  A3_M,
   input  logic [1:0]  tnew_M,
   input  logic        md_start_E,
   input  logic        md_is_div_E,
   input  logic        md_use_D,
   output logic        stall_F,
   output logic        stall_D,
   output logic        flush_E,
   output logic        md_busy,
   output logic        hilo_we,
   output logic [31:0] stall_cnt
);

   mdu_state_e mdu_state;
   logic       dstall;
   logic       mstall;
   logic       stall;

   mdu_busy_fsm #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_mdu_busy_fsm (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (md_start_E),
      .is_div  (md_is_div_E),
      .state   (mdu_state),
      .hilo_we (hilo_we)
   );

   assign dstall = reg_hazard(rs_D, tuse_rs_D, A3_E, tnew_E)
                 | reg_hazard(rs_D, tuse_rs_D, A3_M, tnew_M)
                 | reg_hazard(rt_D, tuse_rt_D, A3_E, tnew_E)
                 | reg_hazard(rt_D, tuse_rt_D, A3_M, tnew_M);

   // The start cycle counts as busy so an mfhi right behind a mult stalls at once.
   assign md_busy = (mdu_state == MDU_BUSY) | md_start_E;
   assign mstall  = md_use_D & md_busy;
   assign stall   = dstall | mstall;

   assign stall_F = stall;
   assign stall_D = stall;
   assign flush_E = stall;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_q <= 32'd0;
      end else if (stall) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign stall_cnt = perf_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
